// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronizes and debounces the coin and cancel sensors,
// credits dollar/fifty coins, drives the accept/reject gate solenoids.
module coin_acceptor #(
  parameter int DEB_CYCLES  = 4,
  parameter int GATE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic coin_sense,
  input  logic coin_type,
  input  logic cancel_btn,
  input  logic insert_coin,
  output logic dollar,
  output logic fifty,
  output logic cancel,
  output logic gate_accept,
  output logic gate_reject,
  output logic busy
);

  localparam logic [7:0] DEB    = 8'(DEB_CYCLES);
  localparam logic [7:0] DEB_M1 = 8'(DEB_CYCLES - 1);
  localparam logic [7:0] GATE   = 8'(GATE_CYCLES);

  typedef enum logic [2:0] {IDLE, DEBOUNCE, ACCEPT, REJECT, WAIT_CLEAR} state_t;

  state_t     state, state_n;
  logic [1:0] sense_sync, type_sync, btn_sync;
  logic [7:0] deb_cnt, deb_n, gate_cnt, gate_n, cancel_cnt, cancel_cnt_n;
  logic       cancel_lock, cancel_lock_n, cancel_pend, cancel_pend_n;
  logic       dollar_n, fifty_n, cancel_n, cancel_req, cancel_fire;
  logic       sense_s, type_s, btn_s;

  assign sense_s = sense_sync[1];
  assign type_s  = type_sync[1];
  assign btn_s   = btn_sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sense_sync  <= '0;
      type_sync   <= '0;
      btn_sync    <= '0;
      state       <= IDLE;
      deb_cnt     <= '0;
      gate_cnt    <= '0;
      cancel_cnt  <= '0;
      cancel_lock <= 1'b0;
      cancel_pend <= 1'b0;
      dollar      <= 1'b0;
      fifty       <= 1'b0;
      cancel      <= 1'b0;
      gate_accept <= 1'b0;
      gate_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      sense_sync  <= {sense_sync[0], coin_sense};
      type_sync   <= {type_sync[0], coin_type};
      btn_sync    <= {btn_sync[0], cancel_btn};
      state       <= state_n;
      deb_cnt     <= deb_n;
      gate_cnt    <= gate_n;
      cancel_cnt  <= cancel_cnt_n;
      cancel_lock <= cancel_lock_n;
      cancel_pend <= cancel_pend_n;
      dollar      <= dollar_n;
      fifty       <= fifty_n;
      cancel      <= cancel_n;
      gate_accept <= (state_n == ACCEPT);
      gate_reject <= (state_n == REJECT);
      busy        <= (state_n != IDLE);
    end
  end

  // Coin FSM; insert_coin and coin_type only matter on the debounce-exit edge,
  // where they are captured as the ACCEPT/REJECT choice and the pulse type.
  always_comb begin
    state_n  = state;
    deb_n    = deb_cnt;
    gate_n   = gate_cnt;
    dollar_n = 1'b0;
    fifty_n  = 1'b0;
    case (state)
      IDLE: begin
        if (sense_s) begin
          state_n = DEBOUNCE;
          deb_n   = 8'd1;
        end
      end
      DEBOUNCE: begin
        if (!sense_s) begin
          state_n = IDLE;
          deb_n   = '0;
        end else if (deb_cnt < DEB) begin
          deb_n = deb_cnt + 8'd1;
        end else begin
          deb_n  = '0;
          gate_n = 8'd1;
          if (insert_coin) begin
            state_n  = ACCEPT;
            dollar_n = type_s;
            fifty_n  = !type_s;
          end else begin
            state_n = REJECT;
          end
        end
      end
      ACCEPT, REJECT: begin
        if (gate_cnt == GATE) begin
          state_n = WAIT_CLEAR;
          gate_n  = '0;
          deb_n   = '0;
        end else begin
          gate_n = gate_cnt + 8'd1;
        end
      end
      WAIT_CLEAR: begin
        if (sense_s) begin
          deb_n = '0;
        end else if (deb_cnt == DEB_M1) begin
          state_n = IDLE;
          deb_n   = '0;
        end else begin
          deb_n = deb_cnt + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        deb_n   = '0;
        gate_n  = '0;
      end
    endcase
  end

  // Cancel qualifier: counts highs while unlocked, then lows to unlock again.
  // A press landing on a coin pulse is held one cycle so the two never overlap.
  always_comb begin
    cancel_cnt_n  = '0;
    cancel_lock_n = cancel_lock;
    cancel_req    = 1'b0;
    if (!cancel_lock) begin
      if (btn_s) begin
        if (cancel_cnt == DEB_M1) begin
          cancel_req    = 1'b1;
          cancel_lock_n = 1'b1;
        end else begin
          cancel_cnt_n = cancel_cnt + 8'd1;
        end
      end
    end else begin
      if (!btn_s) begin
        if (cancel_cnt == DEB_M1) begin
          cancel_lock_n = 1'b0;
        end else begin
          cancel_cnt_n = cancel_cnt + 8'd1;
        end
      end
    end
    cancel_fire   = cancel_req | cancel_pend;
    cancel_n      = cancel_fire & !(dollar_n | fifty_n);
    cancel_pend_n = cancel_fire & (dollar_n | fifty_n);
  end

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive synchronized cycles required to qualify a coin or cancel press (range 2..255).
REQ-002 Parameter GATE_CYCLES, default 8: cycles a gate solenoid output stays asserted (range 1..255).
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 coin_sense  input  1  raw coin-present sensor, asynchronous, may bounce.
REQ-006 coin_type  input  1  raw denomination sensor: 1 = dollar, 0 = fifty cents.
REQ-007 cancel_btn  input  1  raw cancel pushbutton, asynchronous, may bounce.
REQ-008 insert_coin  input  1  vending controller ready-for-coin level.
REQ-009 dollar  output  1  one-cycle pulse: accepted dollar coin.
REQ-010 fifty  output  1  one-cycle pulse: accepted fifty-cent coin.
REQ-011 cancel  output  1  one-cycle pulse: qualified cancel press.
REQ-012 gate_accept  output  1  drives coin into cash box, GATE_CYCLES long.
REQ-013 gate_reject  output  1  drives coin to return chute, GATE_CYCLES long.
REQ-014 busy  output  1  high whenever the coin FSM is not IDLE.

Function
REQ-015 coin_sense, coin_type and cancel_btn SHALL each pass through a 2-flop synchronizer; all logic below uses synchronized values only.
REQ-016 Coin FSM states SHALL be: IDLE, DEBOUNCE, ACCEPT, REJECT, WAIT_CLEAR.
REQ-017 IDLE: sense=1 -> DEBOUNCE, count = 1.
REQ-018 DEBOUNCE: sense=0 -> IDLE, no output; sense=1 and count < DEB_CYCLES -> count+1; sense=1 and count == DEB_CYCLES -> ACCEPT if insert_coin=1, else REJECT.
REQ-019 insert_coin and the synchronized coin_type SHALL be sampled and latched on the DEBOUNCE-exit edge only; later changes have no effect on that coin.
REQ-020 On entering ACCEPT, exactly one of dollar/fifty SHALL pulse for one cycle, selected by the latched type; gate_accept SHALL assert for GATE_CYCLES cycles, then -> WAIT_CLEAR.
REQ-021 REJECT: gate_reject asserted GATE_CYCLES cycles, dollar/fifty never pulse, then -> WAIT_CLEAR.
REQ-022 WAIT_CLEAR: -> IDLE only after DEB_CYCLES consecutive sense=0 cycles; any sense=1 restarts that count; a coin present in this state is never credited.
REQ-023 Latency: with coin_sense first sampled high at edge 1 and held, the dollar/fifty pulse SHALL be high in the cycle after edge DEB_CYCLES+3.
REQ-024 A raw coin_sense high of fewer than DEB_CYCLES+1 cycles SHALL produce no output.
REQ-025 Cancel path: an independent counter SHALL qualify cancel_btn after DEB_CYCLES consecutive high cycles and emit one cancel pulse per press; re-arm requires DEB_CYCLES consecutive low cycles.
REQ-026 cancel SHALL never be high in the same cycle as dollar or fifty; on collision the coin pulse goes first and cancel is emitted in the next cycle.
REQ-027 gate_accept and gate_reject SHALL never be high together; all outputs SHALL be registered.
REQ-028 Cancel qualification SHALL be independent of coin FSM state and of insert_coin.

Reset
REQ-029 While rst=0: coin FSM in IDLE, all counters and synchronizer flops 0, all outputs 0, regardless of clk.
REQ-030 Reset asserted mid-ACCEPT/REJECT SHALL drop gates immediately; after release, operation restarts from IDLE.

Verification (DEB_CYCLES=4, GATE_CYCLES=8)
REQ-031 Reset, insert_coin=1, coin_type=1, coin_sense high 12 cycles from edge 1 -> dollar high only after edge 7, gate_accept high 8 cycles, fifty/gate_reject stay 0.
REQ-032 coin_sense high 4 cycles, then low -> no pulse, no gate, busy returns 0.
REQ-033 insert_coin=0, coin_type=0, coin_sense high 12 cycles -> gate_reject 8 cycles, fifty never pulses.
REQ-034 cancel_btn held 30 cycles with bounces at edges 1-3 -> exactly one cancel pulse; cancel qualifying same cycle as a fifty pulse -> cancel appears one cycle later.
REQ-035 Second coin_sense rise during WAIT_CLEAR with no 4-cycle low gap -> not credited; after 4 low cycles, next coin credited normally.
REQ-036 rst driven low during gate_accept cycle 3 -> all outputs 0 asynchronously; after release with coin_sense=0, busy stays 0.
